// File: rtl/finger_link_tx_pkg.sv
// Shared widths, state encoding and width helper for the finger link transmitter.
// Optional flit counter is enabled with FINGER_LINK_TX_STATS_EN (see finger_link_tx).
package finger_link_tx_pkg;

    // floor(log2(x)) + 1: bits needed to hold the value x itself
    function automatic int unsigned floorplusone_log2(input int unsigned x);
        int unsigned n;
        n = 0;
        for (int unsigned v = x; v != 0; v = v >> 1) begin
            n++;
        end
        return n;
    endfunction

    localparam int unsigned link_flit_size = 1;
    localparam int unsigned link_phit_size = 16;
    localparam int unsigned link_no_vc     = 13;
    localparam int unsigned link_buf_size  = 4;
    localparam int unsigned link_vc_w      = floorplusone_log2(link_no_vc);

    typedef logic [link_phit_size-1:0] phit_t;
    typedef logic [link_vc_w-1:0]      vc_no_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/finger_link_tx_fifo.sv
// Circular flit+VC FIFO with registered full/empty flags; depth need not be a power of two.
module finger_link_tx_fifo
    import finger_link_tx_pkg::*;
#(
    parameter int unsigned data_w = 16,
    parameter int unsigned vc_w   = 4,
    parameter int unsigned depth  = 4
) (
    input  logic              clk,
    input  logic              rs,
    input  logic              wr_en,
    input  logic [data_w-1:0] wr_data,
    input  logic [vc_w-1:0]   wr_vc,
    input  logic              pop,
    output logic [data_w-1:0] head_data,
    output logic [vc_w-1:0]   head_vc,
    output logic              full,
    output logic              empty
);

    localparam int unsigned ptr_w = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned cnt_w = floorplusone_log2(depth);

    logic [data_w-1:0] data_mem [depth];
    logic [vc_w-1:0]   vc_mem   [depth];
    logic [ptr_w-1:0]  wr_ptr;
    logic [ptr_w-1:0]  rd_ptr;
    logic [cnt_w-1:0]  count;
    logic [cnt_w-1:0]  count_nxt_c;
    logic              wr_acc_c;

    // full is based on the registered count, so a write in the same cycle as a pop at full is dropped
    assign wr_acc_c  = wr_en && !full;
    assign head_data = data_mem[rd_ptr];
    assign head_vc   = vc_mem[rd_ptr];

    always_comb begin
        count_nxt_c = count;
        case ({wr_acc_c, pop})
            2'b10:   count_nxt_c = count + cnt_w'(1);
            2'b01:   count_nxt_c = count - cnt_w'(1);
            default: count_nxt_c = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            data_mem[wr_ptr] <= wr_data;
            vc_mem[wr_ptr]   <= wr_vc;
        end
    end

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_acc_c) begin
                wr_ptr <= (wr_ptr == ptr_w'(depth - 1)) ? '0 : wr_ptr + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == ptr_w'(depth - 1)) ? '0 : rd_ptr + ptr_w'(1);
            end
            count <= count_nxt_c;
            full  <= (count_nxt_c == cnt_w'(depth));
            empty <= (count_nxt_c == '0);
        end
    end

endmodule

// File: rtl/finger_link_tx.sv
// Finger link transmitter: buffers whole flits and serializes them phit-by-phit under ready.
// Define FINGER_LINK_TX_STATS_EN to add the tx_flit_cnt sent-flit counter output.
module finger_link_tx
    import finger_link_tx_pkg::*;
#(
    parameter int unsigned flit_size = link_flit_size,
    parameter int unsigned phit_size = link_phit_size,
    parameter int unsigned no_vc     = link_no_vc,
    parameter int unsigned buf_size  = link_buf_size,
    parameter int unsigned idx_w     = floorplusone_log2(flit_size),
    parameter int unsigned vc_w      = floorplusone_log2(no_vc)
) (
    input  logic                          clk,
    input  logic                          rs,
    input  logic                          wr_en,
    input  logic [flit_size*phit_size-1:0] wr_flit,
    input  logic [vc_w-1:0]               wr_vc,
    output logic                          wr_full,
    output logic [phit_size-1:0]          link_data_out,
    output logic                          link_sent_req_out,
    output logic                          link_new_out,
    output logic [vc_w-1:0]               link_vc_no_out,
    input  logic                          link_ready_in,
    output logic                          busy
`ifdef FINGER_LINK_TX_STATS_EN
    ,
    output logic [15:0]                   tx_flit_cnt
`endif
);

    localparam int unsigned flit_w = flit_size * phit_size;

    state_t              state_q, state_d;
    logic [idx_w-1:0]    idx_q, idx_d;
    logic [flit_w-1:0]   flit_q, flit_d;
    logic [vc_w-1:0]     vc_q, vc_d;
    logic                pop;
    logic                fifo_empty;
    logic [flit_w-1:0]   head_data;
    logic [vc_w-1:0]     head_vc;
    logic                last_c;
    logic                xfer_c;

    finger_link_tx_fifo #(
        .data_w (flit_w),
        .vc_w   (vc_w),
        .depth  (buf_size)
    ) u_fifo (
        .clk       (clk),
        .rs        (rs),
        .wr_en     (wr_en),
        .wr_data   (wr_flit),
        .wr_vc     (wr_vc),
        .pop       (pop),
        .head_data (head_data),
        .head_vc   (head_vc),
        .full      (wr_full),
        .empty     (fifo_empty)
    );

    assign last_c = (idx_q == idx_w'(flit_size - 1));
    assign xfer_c = (state_q == SEND) && link_ready_in;

    // Next-state: a finished flit is immediately followed by the FIFO head, so no bubble
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        flit_d  = flit_q;
        vc_d    = vc_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    flit_d  = head_data;
                    vc_d    = head_vc;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (link_ready_in) begin
                    if (!last_c) begin
                        idx_d = idx_q + idx_w'(1);
                    end else if (!fifo_empty) begin
                        pop    = 1'b1;
                        flit_d = head_data;
                        vc_d   = head_vc;
                        idx_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            state_q <= IDLE;
            idx_q   <= '0;
            flit_q  <= '0;
            vc_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            flit_q  <= flit_d;
            vc_q    <= vc_d;
        end
    end

    // Phit select is the only combinational path onto the link
    always_comb begin
        link_data_out = '0;
        for (int i = 0; i < int'(flit_size); i++) begin
            if (idx_q == idx_w'(i)) begin
                link_data_out = flit_q[i*phit_size +: phit_size];
            end
        end
    end

    assign link_sent_req_out = (state_q == SEND);
    assign link_new_out      = (state_q == SEND) && (idx_q == '0);
    assign link_vc_no_out    = vc_q;
    assign busy              = !fifo_empty || (state_q == SEND);

`ifdef FINGER_LINK_TX_STATS_EN
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            tx_flit_cnt <= '0;
        end else if (xfer_c && last_c) begin
            tx_flit_cnt <= tx_flit_cnt + 16'd1;
        end
    end
`else
    logic unused_xfer;
    assign unused_xfer = xfer_c;
`endif

endmodule

// File: tb/tb_finger_link_tx.sv
// Directed bench for finger_link_tx: one-phit instance and two-phit instance sharing clk/rs.
module tb_finger_link_tx;

    logic        clk;
    logic        rs;

    logic        wr_en1, wr_full1, sent1, new1, ready1, busy1;
    logic [15:0] wr_flit1, data1;
    logic [3:0]  wr_vc1, vc1;

    logic        wr_en2, wr_full2, sent2, new2, ready2, busy2;
    logic [31:0] wr_flit2;
    logic [15:0] data2;
    logic [3:0]  wr_vc2, vc2;

`ifdef FINGER_LINK_TX_STATS_EN
    logic [15:0] cnt1, cnt2;
`endif

    int n_checks;
    int n_fail;

    finger_link_tx #(.flit_size(1)) dut1 (
        .clk               (clk),
        .rs                (rs),
        .wr_en             (wr_en1),
        .wr_flit           (wr_flit1),
        .wr_vc             (wr_vc1),
        .wr_full           (wr_full1),
        .link_data_out     (data1),
        .link_sent_req_out (sent1),
        .link_new_out      (new1),
        .link_vc_no_out    (vc1),
        .link_ready_in     (ready1),
        .busy              (busy1)
`ifdef FINGER_LINK_TX_STATS_EN
        ,
        .tx_flit_cnt       (cnt1)
`endif
    );

    finger_link_tx #(.flit_size(2)) dut2 (
        .clk               (clk),
        .rs                (rs),
        .wr_en             (wr_en2),
        .wr_flit           (wr_flit2),
        .wr_vc             (wr_vc2),
        .wr_full           (wr_full2),
        .link_data_out     (data2),
        .link_sent_req_out (sent2),
        .link_new_out      (new2),
        .link_vc_no_out    (vc2),
        .link_ready_in     (ready2),
        .busy              (busy2)
`ifdef FINGER_LINK_TX_STATS_EN
        ,
        .tx_flit_cnt       (cnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rs = 1'b0;
        wr_en1 = 1'b1; wr_flit1 = 16'h5555; wr_vc1 = 4'd1; ready1 = 1'b1;
        wr_en2 = 1'b1; wr_flit2 = 32'h6666_7777; wr_vc2 = 4'd2; ready2 = 1'b1;

        // reset held while writes are requested
        tick(); tick();
        check("rst_sent1", 32'(sent1), 32'd0);
        check("rst_new1",  32'(new1),  32'd0);
        check("rst_data1", 32'(data1), 32'd0);
        check("rst_vc1",   32'(vc1),   32'd0);
        check("rst_full1", 32'(wr_full1), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_sent2", 32'(sent2), 32'd0);
        check("rst_busy2", 32'(busy2), 32'd0);
        wr_en1 = 1'b0; wr_en2 = 1'b0;
        rs = 1'b1;
        tick(); tick(); tick();
        check("post_rst_sent1", 32'(sent1), 32'd0);
        check("post_rst_busy1", 32'(busy1), 32'd0);
        check("post_rst_sent2", 32'(sent2), 32'd0);

        // single one-phit flit
        wr_en1 = 1'b1; wr_flit1 = 16'hA5A5; wr_vc1 = 4'd3;
        tick();
        wr_en1 = 1'b0;
        check("single_sent_e0", 32'(sent1), 32'd0);
        check("single_busy_e0", 32'(busy1), 32'd1);
        tick();
        check("single_sent", 32'(sent1), 32'd1);
        check("single_new",  32'(new1),  32'd1);
        check("single_data", 32'(data1), 32'hA5A5);
        check("single_vc",   32'(vc1),   32'd3);
        tick();
        check("single_sent_done", 32'(sent1), 32'd0);
        check("single_busy_done", 32'(busy1), 32'd0);

        // two-phit flit under backpressure
        ready2 = 1'b0;
        wr_en2 = 1'b1; wr_flit2 = 32'h2222_1111; wr_vc2 = 4'd5;
        tick();
        wr_en2 = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("bp_sent", 32'(sent2), 32'd1);
            check("bp_data", 32'(data2), 32'h1111);
            check("bp_new",  32'(new2),  32'd1);
            check("bp_vc",   32'(vc2),   32'd5);
            tick();
        end
        ready2 = 1'b1;
        check("bp_data_rdy", 32'(data2), 32'h1111);
        tick();
        check("bp_p1_sent", 32'(sent2), 32'd1);
        check("bp_p1_data", 32'(data2), 32'h2222);
        check("bp_p1_new",  32'(new2),  32'd0);
        check("bp_p1_vc",   32'(vc2),   32'd5);
        tick();
        check("bp_done_sent", 32'(sent2), 32'd0);
        check("bp_done_busy", 32'(busy2), 32'd0);

        // fill: first flit moves to the flit register, four more fill the FIFO, sixth dropped
        ready1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_en1 = 1'b1; wr_flit1 = 16'h1000 + 16'(i); wr_vc1 = 4'(i);
            tick();
            if (i == 3) check("fill_full_4", 32'(wr_full1), 32'd0);
            if (i == 4) check("fill_full_5", 32'(wr_full1), 32'd1);
        end
        wr_en1 = 1'b0;
        check("fill_full_hold", 32'(wr_full1), 32'd1);
        check("fill_hold_data", 32'(data1), 32'h1000);
        ready1 = 1'b1;
        for (int j = 0; j < 5; j++) begin
            check("drain_sent", 32'(sent1), 32'd1);
            check("drain_new",  32'(new1),  32'd1);
            check("drain_data", 32'(data1), 32'h1000 + 32'(j));
            check("drain_vc",   32'(vc1),   32'(j));
            tick();
        end
        check("drain_sent_done", 32'(sent1), 32'd0);
        check("drain_busy_done", 32'(busy1), 32'd0);
        check("drain_full_done", 32'(wr_full1), 32'd0);

`ifdef FINGER_LINK_TX_STATS_EN
        check("stats_cnt1", 32'(cnt1), 32'd6);
        check("stats_cnt2", 32'(cnt2), 32'd1);
`endif

        // reset during phit 1 with a second flit queued
        ready2 = 1'b0;
        wr_en2 = 1'b1; wr_flit2 = 32'hBBBB_AAAA; wr_vc2 = 4'd7;
        tick();
        wr_flit2 = 32'hDDDD_CCCC; wr_vc2 = 4'd9;
        tick();
        wr_en2 = 1'b0;
        ready2 = 1'b1;
        check("mid_p0_data", 32'(data2), 32'hAAAA);
        check("mid_p0_new",  32'(new2),  32'd1);
        tick();
        ready2 = 1'b0;
        check("mid_p1_data", 32'(data2), 32'hBBBB);
        check("mid_busy_pre", 32'(busy2), 32'd1);
        rs = 1'b0;
        #1;
        check("mid_rst_sent", 32'(sent2), 32'd0);
        check("mid_rst_new",  32'(new2),  32'd0);
        check("mid_rst_busy", 32'(busy2), 32'd0);
        check("mid_rst_data", 32'(data2), 32'd0);
        rs = 1'b1;
        ready2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mid_after_sent", 32'(sent2), 32'd0);
            check("mid_after_busy", 32'(busy2), 32'd0);
        end
`ifdef FINGER_LINK_TX_STATS_EN
        check("stats_cnt2_rst", 32'(cnt2), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
